// File: rtl/qspi_psram_ctrl.sv
// Quad-SPI PSRAM back end: runs each merged bus request as one 0xEB quad read
// or 0x38 quad write transaction and returns read data or a write-done pulse.
module qspi_psram_ctrl #(
    parameter int unsigned READ_WAIT = 6,
    parameter int unsigned CS_HIGH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_req,
    input  logic        read_w,
    input  logic        read_hw,
    input  logic [31:0] read_adr,
    input  logic        write_req,
    input  logic        write_w,
    input  logic        write_hw,
    input  logic [31:0] write_adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        write_done,
    output logic        busy,
    output logic        qspi_cs_n,
    output logic        qspi_sck,
    output logic [3:0]  qspi_sio_o,
    output logic [3:0]  qspi_sio_oe,
    input  logic [3:0]  qspi_sio_i
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ADR_W   = 24;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned END_LEN = (CS_HIGH > 1) ? CS_HIGH - 1 : 1;
    localparam logic [7:0]  CMD_READ  = 8'hEB;
    localparam logic [7:0]  CMD_WRITE = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_END
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, last_cnt;
    logic                is_wr_q, is_wr_d;
    logic [1:0]          size_q, size_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                read_valid_q, read_valid_d;
    logic                write_done_q, write_done_d;
    logic                busy_q, busy_d;
    logic                cs_n_q, cs_n_d;
    logic                sck_q, sck_d;
    logic [3:0]          sio_o_q, sio_o_d;
    logic [3:0]          sio_oe_q, sio_oe_d;
    logic [4:0]          rsh, wsh, ash;
    logic [2:0]          cmd_bit;
    logic [7:0]          cmd;
    logic                unused_adr_hi;

    assign unused_adr_hi = ^{read_adr[31:24], write_adr[31:24]};

    function automatic logic [1:0] size_of(input logic w, input logic hw);
        return w ? 2'd3 : (hw ? 2'd1 : 2'd0);
    endfunction

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            is_wr_q      <= 1'b0;
            size_q       <= '0;
            adr_q        <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            write_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            sio_o_q      <= '0;
            sio_oe_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            size_q       <= size_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            write_done_q <= write_done_d;
            busy_q       <= busy_d;
            cs_n_q       <= cs_n_d;
            sck_q        <= sck_d;
            sio_o_q      <= sio_o_d;
            sio_oe_q     <= sio_oe_d;
        end
    end

    // Last clk count of each state; two clks per SCK, four per data byte
    always_comb begin
        last_cnt = '0;
        case (state_q)
            ST_CMD:  last_cnt = CNT_W'(15);
            ST_ADDR: last_cnt = CNT_W'(11);
            ST_WAIT: last_cnt = CNT_W'(2 * READ_WAIT - 1);
            ST_DATA: last_cnt = CNT_W'({size_q, 2'b11});
            ST_END:  last_cnt = CNT_W'(END_LEN - 1);
            default: last_cnt = '0;
        endcase
    end

    // Next state, request capture and read nibble assembly
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_wr_d      = is_wr_q;
        size_d       = size_q;
        adr_d        = adr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        write_done_d = 1'b0;
        // Byte at adr first, high nibble first within each byte
        rsh          = {cnt_q[3:2], ~cnt_q[1], 2'b00};

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (write_req) begin
                state_d = ST_CMD;
                is_wr_d = 1'b1;
                size_d  = size_of(write_w, write_hw);
                adr_d   = write_adr[ADR_W-1:0];
                wdata_d = write_data;
                rbuf_d  = '0;
            end else if (read_req) begin
                state_d = ST_CMD;
                is_wr_d = 1'b0;
                size_d  = size_of(read_w, read_hw);
                adr_d   = read_adr[ADR_W-1:0];
                rbuf_d  = '0;
            end
        end else begin
            cnt_d = (cnt_q == last_cnt) ? '0 : cnt_q + CNT_W'(1);
            if (state_q == ST_DATA && !is_wr_q && cnt_q[0]) begin
                rbuf_d = rbuf_q | (DATA_W'(qspi_sio_i) << rsh);
            end
            if (cnt_q == last_cnt) begin
                unique case (state_q)
                    ST_CMD:  state_d = ST_ADDR;
                    ST_ADDR: state_d = (is_wr_q || READ_WAIT == 0) ? ST_DATA : ST_WAIT;
                    ST_WAIT: state_d = ST_DATA;
                    ST_DATA: begin
                        state_d      = ST_END;
                        read_valid_d = !is_wr_q;
                        write_done_d = is_wr_q;
                        if (!is_wr_q) begin
                            read_data_d = rbuf_d;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Pin outputs derived from the upcoming state and count
    always_comb begin
        cs_n_d   = 1'b1;
        sck_d    = 1'b0;
        sio_o_d  = '0;
        sio_oe_d = '0;
        busy_d   = (state_d != ST_IDLE);
        wsh      = {cnt_d[3:2], ~cnt_d[1], 2'b00};
        ash      = 5'd20 - {cnt_d[3:1], 2'b00};
        cmd_bit  = ~cnt_d[3:1];
        cmd      = is_wr_d ? CMD_WRITE : CMD_READ;

        case (state_d)
            ST_CMD: begin
                cs_n_d   = 1'b0;
                sck_d    = cnt_d[0];
                sio_o_d  = {3'b000, cmd[cmd_bit]};
                sio_oe_d = 4'b0001;
            end
            ST_ADDR: begin
                cs_n_d   = 1'b0;
                sck_d    = cnt_d[0];
                sio_o_d  = 4'(adr_d >> ash);
                sio_oe_d = 4'b1111;
            end
            ST_WAIT: begin
                cs_n_d = 1'b0;
                sck_d  = cnt_d[0];
            end
            ST_DATA: begin
                cs_n_d = 1'b0;
                sck_d  = cnt_d[0];
                if (is_wr_d) begin
                    sio_o_d  = 4'(wdata_d >> wsh);
                    sio_oe_d = 4'b1111;
                end
            end
            default: ;
        endcase
    end

    assign read_data   = read_data_q;
    assign read_valid  = read_valid_q;
    assign write_done  = write_done_q;
    assign busy        = busy_q;
    assign qspi_cs_n   = cs_n_q;
    assign qspi_sck    = sck_q;
    assign qspi_sio_o  = sio_o_q;
    assign qspi_sio_oe = sio_oe_q;

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Bench for qspi_psram_ctrl: a byte-addressed PSRAM model on the pins plus a
// reference memory; directed and random transactions checked with assertions.
module tb_qspi_psram_ctrl;

    localparam int RW  = 6;
    localparam int CSH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_req = 1'b0, read_w = 1'b0, read_hw = 1'b0;
    logic [31:0] read_adr = '0;
    logic        write_req = 1'b0, write_w = 1'b0, write_hw = 1'b0;
    logic [31:0] write_adr = '0, write_data = '0;
    logic [31:0] read_data;
    logic        read_valid, write_done, busy;
    logic        qspi_cs_n, qspi_sck;
    logic [3:0]  qspi_sio_o, qspi_sio_oe;
    logic [3:0]  qspi_sio_i = 4'h0;

    logic        rd2_req = 1'b0;
    logic [31:0] rd2_data;
    logic        rd2_valid, wr2_done, busy2, cs2_n, sck2;
    logic [3:0]  sio2_o, sio2_oe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qspi_psram_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
        .write_req(write_req), .write_w(write_w), .write_hw(write_hw),
        .write_adr(write_adr), .write_data(write_data),
        .read_data(read_data), .read_valid(read_valid), .write_done(write_done), .busy(busy),
        .qspi_cs_n(qspi_cs_n), .qspi_sck(qspi_sck), .qspi_sio_o(qspi_sio_o),
        .qspi_sio_oe(qspi_sio_oe), .qspi_sio_i(qspi_sio_i)
    );

    qspi_psram_ctrl #(.READ_WAIT(4), .CS_HIGH(3)) dut_sweep (
        .clk(clk), .rst_n(rst_n),
        .read_req(rd2_req), .read_w(1'b1), .read_hw(1'b0), .read_adr(32'h0000_0040),
        .write_req(1'b0), .write_w(1'b0), .write_hw(1'b0),
        .write_adr(32'h0), .write_data(32'h0),
        .read_data(rd2_data), .read_valid(rd2_valid), .write_done(wr2_done), .busy(busy2),
        .qspi_cs_n(cs2_n), .qspi_sck(sck2), .qspi_sio_o(sio2_o),
        .qspi_sio_oe(sio2_oe), .qspi_sio_i(4'h9)
    );

    // Device storage (written over the pins) and the bench's own reference
    logic [7:0]  mem     [int unsigned];
    logic [7:0]  ref_mem [int unsigned];
    logic [7:0]  cmd_log [$];
    logic [23:0] adr_log [$];

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return 8'(a ^ (a >> 8) ^ 24'h5A);
    endfunction

    function automatic logic [7:0] dev_byte(input logic [23:0] a);
        return mem.exists(32'(a)) ? mem[32'(a)] : dflt(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : dflt(a);
    endfunction

    // PSRAM pin model: count SCK rises since cs_n fell and decode the frame
    int          dev_k = 0;
    int          dev_j = 0;
    int          oe_err = 0;
    int          sck_err = 0;
    logic [7:0]  dev_cmd = '0;
    logic [23:0] dev_adr = '0;
    logic [3:0]  dev_hi = '0;
    logic [7:0]  dev_b = '0;

    always @(posedge qspi_sck or posedge qspi_cs_n) begin
        if (qspi_cs_n === 1'b1) begin
            if (qspi_sck === 1'b1) sck_err++;
            if (dev_k >= 8) begin
                cmd_log.push_back(dev_cmd);
                adr_log.push_back(dev_adr);
            end
            dev_k   = 0;
            dev_cmd = '0;
            dev_adr = '0;
        end else begin
            if (dev_k < 8) begin
                dev_cmd = {dev_cmd[6:0], qspi_sio_o[0]};
                if (qspi_sio_oe !== 4'b0001 || qspi_sio_o[3:1] !== 3'b000) oe_err++;
            end else if (dev_k < 14) begin
                dev_adr = {dev_adr[19:0], qspi_sio_o};
                if (qspi_sio_oe !== 4'b1111) oe_err++;
            end else if (dev_cmd == 8'h38) begin
                if (qspi_sio_oe !== 4'b1111) oe_err++;
                dev_j = dev_k - 14;
                if (dev_j % 2 == 0) dev_hi = qspi_sio_o;
                else mem[32'(24'(dev_adr + 24'(dev_j / 2)))] = {dev_hi, qspi_sio_o};
            end else begin
                if (qspi_sio_oe !== 4'b0000) oe_err++;
                if (dev_k >= 14 + RW) begin
                    dev_j = dev_k - 14 - RW;
                    dev_b = dev_byte(24'(dev_adr + 24'(dev_j / 2)));
                    qspi_sio_i = (dev_j % 2 == 0) ? dev_b[7:4] : dev_b[3:0];
                end
            end
            dev_k++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    // One transaction; latency counted in clk edges after the accept edge
    task automatic run_txn(input bit wr, input bit w, input bit hw,
                           input logic [23:0] adr, input logic [31:0] data);
        int          nb, lat, n;
        logic [31:0] exp_rd, got_mem, exp_mem;
        nb     = w ? 4 : (hw ? 2 : 1);
        lat    = 1 + 2 * (8 + 6) + (wr ? 0 : 2 * RW) + 4 * nb;
        exp_rd = '0;
        for (int i = 0; i < nb; i++)
            exp_rd |= 32'(ref_byte(24'(adr + 24'(i)))) << (8 * i);
        wait_idle();
        if (wr) begin
            write_req = 1'b1; write_w = w; write_hw = hw;
            write_adr = {8'($urandom), adr}; write_data = data;
        end else begin
            read_req = 1'b1; read_w = w; read_hw = hw;
            read_adr = {8'($urandom), adr};
        end
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("busy_after_accept", 32'(busy), 32'h1);
                chk("cs_n_after_accept", 32'(qspi_cs_n), 32'h0);
            end
            if ((wr ? write_done : read_valid) === 1'b1) break;
        end
        chk(wr ? "write_latency" : "read_latency", 32'(n), 32'(lat));
        if (!wr) chk("read_data", read_data, exp_rd);
        chk("other_pulse_low", 32'(wr ? read_valid : write_done), 32'h0);
        read_req  = 1'b0;
        write_req = 1'b0;
        chk("txn_cmd", 32'(cmd_log[$]), wr ? 32'h38 : 32'hEB);
        chk("txn_adr", 32'(adr_log[$]), 32'(adr));
        chk("oe_errors", 32'(oe_err), 32'h0);
        @(negedge clk);
        chk("pulse_one_clk", 32'(wr ? write_done : read_valid), 32'h0);
        if (wr) begin
            got_mem = '0;
            exp_mem = '0;
            for (int i = 0; i < nb; i++) begin
                ref_mem[32'(24'(adr + 24'(i)))] = 8'(data >> (8 * i));
                got_mem |= 32'(dev_byte(24'(adr + 24'(i)))) << (8 * i);
                exp_mem |= 32'(8'(data >> (8 * i))) << (8 * i);
            end
            chk("device_bytes", got_mem, exp_mem);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pool [$];
        logic [23:0] a;
        logic [31:0] d;
        int          n, gap;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(qspi_cs_n), 32'h1);
        chk("rst_sck", 32'(qspi_sck), 32'h0);
        chk("rst_oe", 32'(qspi_sio_oe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_read_data", read_data, 32'h0);
        rst_n = 1'b1;

        // Directed: word write, then word / halfword / byte reads
        run_txn(1'b1, 1'b1, 1'b0, 24'h000123, 32'hA1B2C3D4);
        run_txn(1'b0, 1'b1, 1'b0, 24'h000123, 32'h0);
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 32'(i)]     = 8'(32'h12345678 >> (8 * i));
            ref_mem[32'h100 + 32'(i)] = 8'(32'h12345678 >> (8 * i));
        end
        mem[32'h200] = 8'hEF; mem[32'h201] = 8'hBE; mem[32'h300] = 8'h80;
        ref_mem[32'h200] = 8'hEF; ref_mem[32'h201] = 8'hBE; ref_mem[32'h300] = 8'h80;
        run_txn(1'b0, 1'b1, 1'b0, 24'h000100, 32'h0);
        chk("word_read_literal", read_data, 32'h12345678);
        run_txn(1'b0, 1'b0, 1'b1, 24'h000200, 32'h0);
        chk("hw_read_literal", read_data, 32'h0000BEEF);
        run_txn(1'b0, 1'b0, 1'b0, 24'h000300, 32'h0);
        chk("byte_read_literal", read_data, 32'h00000080);
        run_txn(1'b1, 1'b0, 1'b1, 24'h000400, 32'hFFFF5AA5);
        run_txn(1'b1, 1'b0, 1'b0, 24'h000500, 32'h000000C3);

        // Simultaneous requests: write wins, read follows after the gap
        wait_idle();
        write_req = 1'b1; write_w = 1'b1; write_hw = 1'b0;
        write_adr = 32'h0000_0600; write_data = 32'h0BADF00D;
        read_req = 1'b1; read_w = 1'b1; read_hw = 1'b0; read_adr = 32'h0000_0600;
        n = 0;
        while (n < 200 && write_done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("arb_write_latency", 32'(n), 32'd45);
        chk("arb_first_cmd", 32'(cmd_log[$]), 32'h38);
        chk("arb_no_read_yet", 32'(read_valid), 32'h0);
        write_req = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[32'h600 + 32'(i)] = 8'(32'h0BADF00D >> (8 * i));
        gap = 1;
        while (gap < 50) begin
            @(negedge clk);
            if (qspi_cs_n === 1'b0) break;
            gap++;
        end
        chk("arb_cs_gap", 32'(gap), 32'(CSH));
        n = 1;
        while (n < 200 && read_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        read_req = 1'b0;
        chk("arb_read_latency", 32'(n), 32'd57);
        chk("arb_read_data", read_data, 32'h0BADF00D);
        chk("arb_second_cmd", 32'(cmd_log[$]), 32'hEB);

        // Random traffic against the reference memory, including address wrap
        for (int i = 0; i < 14; i++) begin
            a = (i % 5 == 0) ? 24'hFFFFFE :
                ((pool.size() > 0 && $urandom_range(1, 0) == 1) ? pool[$urandom_range(pool.size() - 1, 0)]
                                                               : 24'($urandom));
            d = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                pool.push_back(a);
                run_txn(1'b1, 1'($urandom), 1'($urandom), a, d);
            end else begin
                run_txn(1'b0, 1'($urandom), 1'($urandom), a, 32'h0);
            end
        end

        // Reset in the middle of a read data phase
        wait_idle();
        read_req = 1'b1; read_w = 1'b1; read_hw = 1'b0; read_adr = 32'h0000_0100;
        repeat (50) @(negedge clk);
        chk("mid_read_cs_low", 32'(qspi_cs_n), 32'h0);
        rst_n = 1'b0;
        read_req = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 32'(qspi_cs_n), 32'h1);
        chk("abort_sck", 32'(qspi_sck), 32'h0);
        chk("abort_oe", 32'(qspi_sio_oe), 32'h0);
        chk("abort_sio_o", 32'(qspi_sio_o), 32'h0);
        chk("abort_no_valid", 32'(read_valid), 32'h0);
        chk("abort_read_data", read_data, 32'h0);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || read_valid !== 1'b0 || qspi_cs_n !== 1'b1) n++;
        end
        chk("post_abort_quiet", 32'(n), 32'h0);
        chk("sck_only_with_cs", 32'(sck_err), 32'h0);

        // READ_WAIT=4, CS_HIGH=3 instance: latency, data and back-to-back gap
        @(negedge clk);
        rd2_req = 1'b1;
        n = 0;
        while (n < 200 && rd2_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_latency", 32'(n), 32'd53);
        chk("sweep_data", rd2_data, 32'h99999999);
        gap = 1;
        while (gap < 50) begin
            @(negedge clk);
            if (cs2_n === 1'b0) break;
            gap++;
        end
        chk("sweep_cs_gap", 32'(gap), 32'd3);
        n = 1;
        while (n < 200 && rd2_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        rd2_req = 1'b0;
        chk("sweep_latency_b2b", 32'(n), 32'd53);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
